// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the oversampled UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Clocks per oversample tick; never below one so the tick can free-run at clk rate.
    function automatic int calc_div(input int sys_clk, input int baud, input int os);
        int d;
        d = sys_clk / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

    // The three sample indices around mid-bit that feed the majority vote.
    function automatic int mid_lo_idx(input int os);
        return os / 2 - 1;
    endfunction

    function automatic int mid_idx(input int os);
        return os / 2;
    endfunction

    function automatic int mid_hi_idx(input int os);
        return os / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// rtl/uart_os_tick_gen.sv - free-running oversample tick, one clk wide every DIV clks
module uart_os_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Wrap the divider at DIV-1; the tick is the wrap cycle itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver; UART_RX_PARITY_EN adds a parity bit and parity_err
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int SYSTEM_CLK = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_pin,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  framing_err,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  overrun_err
);

    localparam int DIV = calc_div(SYSTEM_CLK, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] IDX_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] MID_LO   = CW'(mid_lo_idx(OVERSAMPLE));
    localparam logic [CW-1:0] MID      = CW'(mid_idx(OVERSAMPLE));
    localparam logic [CW-1:0] MID_HI   = CW'(mid_hi_idx(OVERSAMPLE));
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic                  tick;
    logic                  sync1, sync2, rx_s;
    logic                  prev_s;
    rx_state_e             state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         idx_next;
    logic [BW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  s_lo, s_mid;
    logic                  vote;
    logic                  frame_ok;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad;
    logic                  par_mismatch;
`endif

    uart_os_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_pin;
            sync2 <= sync1;
        end
    end

    assign rx_s = sync2;

    // Sample index within the current bit, wrapping at the bit boundary.
    assign idx_next = (cnt == IDX_LAST) ? '0 : cnt + CW'(1);

    // Majority of the two stored mid-bit samples and the live third one.
    assign vote = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);

`ifdef UART_RX_PARITY_EN
    assign par_mismatch = ((^shreg) ^ vote) != PARITY_ODD[0];
    assign frame_ok = tick && (state == STOP) && (idx_next == MID_HI) && vote
                      && (stop_cnt == STOP_LAST) && !par_bad;
`else
    assign frame_ok = tick && (state == STOP) && (idx_next == MID_HI) && vote
                      && (stop_cnt == STOP_LAST);
`endif

    // Frame FSM: start detection on a sampled falling edge, then per-bit voting at mid-bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            shreg       <= '0;
            s_lo        <= 1'b1;
            s_mid       <= 1'b1;
            prev_s      <= 1'b1;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (tick) begin
                prev_s <= rx_s;
                if (state == IDLE) begin
                    // Requiring the previous sample high makes a stuck-low line re-arm only after it recovers.
                    if (prev_s && !rx_s) begin
                        state    <= START;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_bad  <= 1'b0;
`endif
                    end
                end else begin
                    cnt <= idx_next;
                    if (idx_next == MID_LO) s_lo <= rx_s;
                    if (idx_next == MID) s_mid <= rx_s;
                    if (idx_next == MID_HI) begin
                        case (state)
                            START: state <= vote ? IDLE : DATA;
                            DATA: begin
                                shreg <= {vote, shreg[DATA_WIDTH-1:1]};
                                if (bit_cnt == BIT_LAST) begin
                                    bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                    state   <= PARITY;
`else
                                    state   <= STOP;
`endif
                                end else begin
                                    bit_cnt <= bit_cnt + BW'(1);
                                end
                            end
`ifdef UART_RX_PARITY_EN
                            PARITY: begin
                                par_bad    <= par_mismatch;
                                parity_err <= par_mismatch;
                                state      <= STOP;
                            end
`endif
                            STOP: begin
                                if (!vote) begin
                                    framing_err <= 1'b1;
                                    state       <= IDLE;
                                end else if (stop_cnt == STOP_LAST) begin
                                    state <= IDLE;
                                end else begin
                                    stop_cnt <= stop_cnt + 1'b1;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            end
        end
    end

    // Output holding register: load on a good frame unless an unaccepted byte would be overwritten.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_ok) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed frames against a frame-level model of the receiver
module tb_uart_rx_oversampled;
    import uart_pkg::*;

    localparam int DW       = 8;
    localparam int OS       = 16;
    localparam int SYNC_LAT = 3;
    localparam int T_DONE   = OS * (1 + DW) + OS / 2 + 1 + SYNC_LAT;

    typedef struct {
        int         t;
        bit         fe;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_pin;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun_err;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  fe_seen = 0;
    int  oe_seen = 0;
    int  rise_cyc = -1;
    int  t0_last = 0;
    ev_t ev_q[$];

    logic       exp_valid, exp_fe, exp_oe, prev_valid;
    logic [7:0] exp_data;

    uart_rx_oversampled #(
        .DATA_WIDTH(DW),
        .STOP_BITS (1),
        .SYSTEM_CLK(1_600_000),
        .BAUD_RATE (100_000),
        .OVERSAMPLE(OS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_pin     (rx_pin),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .framing_err(framing_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, got, want);
        end
    endtask

    // Model: each frame produces one event at a fixed offset from its start edge.
    initial begin
        ev_t ev;
        exp_valid  = 1'b0;
        exp_data   = '0;
        exp_fe     = 1'b0;
        exp_oe     = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            exp_fe = 1'b0;
            exp_oe = 1'b0;
            if (!reset) begin
                exp_valid = 1'b0;
                exp_data  = '0;
                ev_q.delete();
            end else if (ev_q.size() > 0 && ev_q[0].t == cyc) begin
                ev = ev_q.pop_front();
                if (ev.fe) begin
                    exp_fe = 1'b1;
                    if (exp_valid && rx_ready) exp_valid = 1'b0;
                end else if (!exp_valid || rx_ready) begin
                    exp_valid = 1'b1;
                    exp_data  = ev.d;
                end else begin
                    exp_oe = 1'b1;
                end
            end else if (exp_valid && rx_ready) begin
                exp_valid = 1'b0;
            end
            chk("rx_valid", rx_valid, exp_valid);
            chk("rx_data", rx_data, exp_data);
            chk("framing_err", framing_err, exp_fe);
            chk("overrun_err", overrun_err, exp_oe);
            if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
            prev_valid = rx_valid;
            if (framing_err === 1'b1) fe_seen++;
            if (overrun_err === 1'b1) oe_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_pin = 1'b1;
        end
    endtask

    // One start bit, eight data bits LSB first, one stop bit, 16 clk each.
    task automatic drive_frame(input logic [7:0] d, input logic stop_v,
                               input int spike_c, input int abort_c);
        logic line [0:159];
        ev_t  ev;
        for (int i = 0; i < 160; i++) line[i] = 1'b1;
        for (int i = 0; i < 16; i++) line[i] = 1'b0;
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 16; i++) line[16 * (b + 1) + i] = d[b];
        for (int i = 0; i < 16; i++) line[144 + i] = stop_v;
        if (spike_c >= 0) line[spike_c] = 1'b0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (c == abort_c) begin
                reset  = 1'b0;
                rx_pin = 1'b1;
                repeat (3) @(negedge clk);
                chk("reset_mid_valid", rx_valid, 1'b0);
                chk("reset_mid_data", rx_data, 8'h00);
                chk("reset_mid_fe", framing_err, 1'b0);
                chk("reset_mid_oe", overrun_err, 1'b0);
                reset = 1'b1;
                return;
            end
            rx_pin = line[c];
            if (c == 0) begin
                t0_last = cyc;
                ev.t    = cyc + T_DONE;
                ev.fe   = !stop_v;
                ev.d    = d;
                ev_q.push_back(ev);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        rx_pin   = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_fe", framing_err, 1'b0);
        chk("reset_oe", overrun_err, 1'b0);
        reset = 1'b1;
        idle(20);

        drive_frame(8'hA5, 1'b1, -1, -1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_valid_gone", rx_valid, 1'b0);
        chk("a5_latency", rise_cyc - t0_last, 156);
        idle(10);

        rx_ready = 1'b0;
        drive_frame(8'h3C, 1'b1, -1, -1);
        idle(5);
        drive_frame(8'h81, 1'b1, -1, -1);
        chk("overrun_data_kept", rx_data, 8'h3C);
        chk("overrun_valid_held", rx_valid, 1'b1);
        chk("overrun_once", oe_seen, 1);
        @(negedge clk);
        rx_ready = 1'b1;
        idle(3);
        chk("accept_valid_low", rx_valid, 1'b0);
        chk("accept_data_kept", rx_data, 8'h3C);

        drive_frame(8'h55, 1'b0, -1, -1);
        idle(20);
        chk("framing_once", fe_seen, 1);
        chk("framing_no_valid", rx_valid, 1'b0);
        drive_frame(8'h12, 1'b1, -1, -1);
        chk("after_framing_data", rx_data, 8'h12);

        repeat (5) begin
            @(negedge clk);
            rx_pin = 1'b0;
        end
        idle(30);
        chk("glitch_idle", 32'(dut.state), 32'(IDLE));
        chk("glitch_no_fe", fe_seen, 1);
        chk("glitch_data_kept", rx_data, 8'h12);

        drive_frame(8'hFF, 1'b1, 72, -1);
        chk("spike_data", rx_data, 8'hFF);
        idle(10);

        rx_ready = 1'b0;
        drive_frame(8'h99, 1'b1, -1, -1);
        chk("held_99", rx_data, 8'h99);
        idle(5);
        drive_frame(8'h7E, 1'b1, -1, 88);
        rx_ready = 1'b1;
        idle(20);
        drive_frame(8'h7E, 1'b1, -1, -1);
        chk("after_reset_data", rx_data, 8'h7E);
        chk("after_reset_latency", rise_cyc - t0_last, 156);
        idle(5);

        chk("events_drained", ev_q.size(), 0);
        chk("total_overrun", oe_seen, 1);
        chk("total_framing", fe_seen, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
